store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 159 +++++++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
//==============================================================================
// Module  : store_buffer
// Brief   : In-order store buffer with SB/SH/SW lane formatting, load-conflict
//           detection and fence drain.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  f3_in,
    output logic        st_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    input  logic        fence_req,
    output logic        fence_done,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FENCE = 1'b1
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_valid;
    logic               r_err;

    logic [29:0]        r_addr  [DEPTH];
    logic [31:0]        r_wdata [DEPTH];
    logic [3:0]         r_be    [DEPTH];

    logic               w_legal;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_conflict;
    logic               w_unused_ld;

    // Lane formatting and alignment check of the incoming store.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = st_data;
        case (f3_in)
            3'b000: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << st_addr[1:0];
                w_wdata = {4{st_data[7:0]}};
            end
            3'b001: begin
                w_legal = ~st_addr[0];
                w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data[15:0]}};
            end
            3'b010: begin
                w_legal = (st_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = st_data;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign st_ready = (r_count < c_depth) && (r_state == RUN);
    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = mem_req && mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;

            // Push and pop never hit the same slot: that needs empty and full at once.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                RUN:     if (fence_req) r_state <= FENCE;
                FENCE:   if (r_count == '0) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Payload is qualified by r_valid/r_count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr]  <= st_addr[31:2];
            r_wdata[r_wr_ptr] <= w_wdata;
            r_be[r_wr_ptr]    <= w_be;
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == ld_addr[31:2])) begin
                w_conflict = 1'b1;
            end
        end
    end

    assign w_unused_ld = &{1'b0, ld_addr[1:0]};

    assign ld_conflict = w_conflict;
    assign st_err      = r_err;
    assign mem_req     = (r_count != '0);
    assign empty       = (r_count == '0);
    assign fence_done  = (r_state == FENCE) && (r_count == '0);
    assign mem_addr    = {r_addr[r_rd_ptr], 2'b00};
    assign mem_wdata   = r_wdata[r_rd_ptr];
    assign mem_be      = r_be[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
//==============================================================================
// Module  : tb_store_buffer
// Brief   : Directed self-checking bench for store_buffer (DEPTH = 4).
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  f3_in;
    logic        st_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        fence_req;
    logic        fence_done;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .f3_in      (f3_in),
        .st_err     (st_err),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .ld_addr    (ld_addr),
        .ld_conflict(ld_conflict),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        f3_in    = f;
    endtask

    int pulses;
    int done_cyc;

    initial begin
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; f3_in = 3'b000;
        mem_ack = 1'b0; ld_addr = 32'hFFFF_FFF0; fence_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_st_err", st_err, 0);
        chk("rst_fence_done", fence_done, 0);
        chk("rst_ld_conflict", ld_conflict, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_st_ready", st_ready, 1);

        // SB at 0x1003 with ack tied high
        mem_ack = 1'b1;
        put(32'h1003, 32'h0000_00A5, 3'b000);
        tick();
        st_valid = 1'b0;
        chk("sb_req", mem_req, 1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_not_empty", empty, 0);
        tick();
        chk("sb_req_done", mem_req, 0);
        chk("sb_empty", empty, 1);

        // Misaligned SH
        put(32'h2001, 32'h0000_BEEF, 3'b001);
        tick();
        st_valid = 1'b0;
        chk("sh_bad_err", st_err, 1);
        chk("sh_bad_req", mem_req, 0);
        chk("sh_bad_empty", empty, 1);
        tick();
        chk("sh_bad_err_clr", st_err, 0);

        // Illegal funct3
        put(32'h2000, 32'h1, 3'b011);
        tick();
        st_valid = 1'b0;
        chk("f3_bad_err", st_err, 1);
        chk("f3_bad_empty", empty, 1);

        // Misaligned SW
        put(32'h4002, 32'h1, 3'b010);
        tick();
        st_valid = 1'b0;
        chk("sw_bad_err", st_err, 1);
        chk("sw_bad_empty", empty, 1);

        // Aligned SH upper half
        put(32'h2002, 32'h1234_BEEF, 3'b001);
        tick();
        st_valid = 1'b0;
        chk("sh_err", st_err, 0);
        chk("sh_addr", mem_addr, 32'h2000);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        tick();
        chk("sh_empty", empty, 1);

        // Fill to DEPTH with ack held low, fifth store must stall
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h5000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 3'b010);
            chk("fill_ready", st_ready, 1);
            tick();
        end
        put(32'h5010, 32'h5555_5555, 3'b010);
        chk("full_ready", st_ready, 0);
        tick();
        chk("full_hold_ready", st_ready, 0);
        chk("full_head_addr", mem_addr, 32'h5000);
        mem_ack = 1'b1;
        chk("drain0_addr", mem_addr, 32'h5000);
        chk("drain0_wdata", mem_wdata, 32'h1111_1111);
        tick();
        chk("drain1_ready", st_ready, 1);
        chk("drain1_addr", mem_addr, 32'h5004);
        chk("drain1_wdata", mem_wdata, 32'h2222_2222);
        tick();
        st_valid = 1'b0;
        chk("drain2_addr", mem_addr, 32'h5008);
        chk("drain2_wdata", mem_wdata, 32'h3333_3333);
        tick();
        chk("drain3_addr", mem_addr, 32'h500C);
        chk("drain3_wdata", mem_wdata, 32'h4444_4444);
        tick();
        chk("drain4_addr", mem_addr, 32'h5010);
        chk("drain4_wdata", mem_wdata, 32'h5555_5555);
        chk("drain4_be", mem_be, 4'b1111);
        tick();
        chk("drain_empty", empty, 1);

        // Load conflict detection
        mem_ack = 1'b0;
        put(32'h3000, 32'h1, 3'b010);
        tick();
        put(32'h3004, 32'h2, 3'b010);
        tick();
        st_valid = 1'b0;
        ld_addr = 32'h3008;
        #1;
        chk("ld_miss", ld_conflict, 0);
        ld_addr = 32'h3006;
        #1;
        chk("ld_hit_two", ld_conflict, 1);
        mem_ack = 1'b1;
        tick();
        chk("ld_hit_one", ld_conflict, 1);
        chk("ld_head", mem_addr, 32'h3004);
        tick();
        chk("ld_clear", ld_conflict, 0);
        chk("ld_empty", empty, 1);
        ld_addr = 32'hFFFF_FFF0;

        // Fence while empty
        mem_ack = 1'b0;
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        chk("fence_e_done", fence_done, 1);
        chk("fence_e_ready", st_ready, 0);
        tick();
        chk("fence_e_done_clr", fence_done, 0);
        chk("fence_e_run", st_ready, 1);

        // Fence with three stores, ack every other cycle
        for (int i = 0; i < 3; i++) begin
            put(32'h6000 + 32'(4 * i), 32'(i), 3'b010);
            tick();
        end
        st_valid = 1'b0;
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        pulses = 0;
        done_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            mem_ack   = c[0];
            fence_req = (c == 2);
            #1;
            if (fence_done) begin
                pulses++;
                done_cyc = c;
                chk("fence_done_empty", empty, 1);
            end
            if (done_cyc < 0) chk("fence_ready_low", st_ready, 0);
            tick();
        end
        mem_ack = 1'b0;
        fence_req = 1'b0;
        chk("fence_pulses", 32'(pulses), 1);
        chk("fence_done_cycle", 32'(done_cyc), 6);
        chk("fence_back_ready", st_ready, 1);

        // Asynchronous reset mid-handshake
        put(32'h7000, 32'hA, 3'b010);
        tick();
        put(32'h7004, 32'hB, 3'b010);
        tick();
        st_valid = 1'b0;
        chk("arst_pre_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_empty", empty, 1);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("arst_no_write", mem_req, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
